// File: rtl/instr_sequencer.sv
// Eight-phase instruction sequencer: steps S0..S7 for each instruction and drives
// registered fetch, PC, memory, data-bus and accumulator strobes from the IR opcode.
module instr_sequencer #(
  parameter bit SKZ_NEED_VALID = 1'b1
) (
  input  logic       clk1,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       acc_valid,
  output logic       inc_pc,
  output logic       load_ir,
  output logic       rd,
  output logic       wr,
  output logic       load_acc,
  output logic       load_pc,
  output logic       datactl_ena,
  output logic       halt,
  output logic [3:0] phase
);

  localparam logic [2:0] OP_HLT  = 3'b000;
  localparam logic [2:0] OP_SKZ  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ANDD = 3'b011;
  localparam logic [2:0] OP_XORR = 3'b100;
  localparam logic [2:0] OP_LDA  = 3'b101;
  localparam logic [2:0] OP_STO  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  typedef enum logic [3:0] {
    S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3,
    S4 = 4'd4, S5 = 4'd5, S6 = 4'd6, S7 = 4'd7,
    IDLE = 4'd8, HALT = 4'd9
  } state_t;

  state_t state_q, state_d;
  logic inc_pc_q, load_ir_q, rd_q, wr_q, load_acc_q, load_pc_q, datactl_ena_q, halt_q;
  logic inc_pc_d, load_ir_d, rd_d, wr_d, load_acc_d, load_pc_d, datactl_ena_d, halt_d;
  logic alu_op, is_sto, is_jmp, skz_take;

  assign alu_op   = (opcode == OP_ADD) || (opcode == OP_ANDD) ||
                    (opcode == OP_XORR) || (opcode == OP_LDA);
  assign is_sto   = (opcode == OP_STO);
  assign is_jmp   = (opcode == OP_JMP);
  assign skz_take = (opcode == OP_SKZ) && zero && (acc_valid || !SKZ_NEED_VALID);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALT: if (start) state_d = S0;
      S0:      state_d = S1;
      S1:      state_d = S2;
      S2:      state_d = S3;
      S3:      state_d = (opcode == OP_HLT) ? HALT : S4;
      S4:      state_d = S5;
      S5:      state_d = S6;
      S6:      state_d = S7;
      S7:      state_d = S0;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they line up with phase.
  always_comb begin
    inc_pc_d      = 1'b0;
    load_ir_d     = 1'b0;
    rd_d          = 1'b0;
    wr_d          = 1'b0;
    load_acc_d    = 1'b0;
    load_pc_d     = 1'b0;
    datactl_ena_d = 1'b0;
    halt_d        = 1'b0;
    case (state_d)
      S0, S1: begin
        rd_d      = 1'b1;
        load_ir_d = 1'b1;
        inc_pc_d  = 1'b1;
      end
      S3: inc_pc_d = (opcode != OP_HLT);
      S4: begin
        rd_d          = alu_op;
        load_pc_d     = is_jmp;
        datactl_ena_d = is_sto;
      end
      S5: begin
        if (alu_op) begin
          rd_d       = 1'b1;
          load_acc_d = 1'b1;
        end else if (is_sto) begin
          datactl_ena_d = 1'b1;
          wr_d          = 1'b1;
        end else if (is_jmp) begin
          load_pc_d = 1'b1;
          inc_pc_d  = 1'b1;
        end else begin
          inc_pc_d = skz_take;
        end
      end
      S6: begin
        rd_d          = alu_op;
        datactl_ena_d = is_sto;
      end
      S7:      inc_pc_d = skz_take;
      HALT:    halt_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q       <= IDLE;
      inc_pc_q      <= 1'b0;
      load_ir_q     <= 1'b0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      load_acc_q    <= 1'b0;
      load_pc_q     <= 1'b0;
      datactl_ena_q <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      inc_pc_q      <= inc_pc_d;
      load_ir_q     <= load_ir_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      load_acc_q    <= load_acc_d;
      load_pc_q     <= load_pc_d;
      datactl_ena_q <= datactl_ena_d;
      halt_q        <= halt_d;
    end
  end

  assign inc_pc      = inc_pc_q;
  assign load_ir     = load_ir_q;
  assign rd          = rd_q;
  assign wr          = wr_q;
  assign load_acc    = load_acc_q;
  assign load_pc     = load_pc_q;
  assign datactl_ena = datactl_ena_q;
  assign halt        = halt_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes hand-computed per-cycle
// {phase, strobes} into a queue; a monitor pops and compares one entry per cycle.
module tb_instr_sequencer;

  logic       clk1 = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;
  logic       acc_valid = 1'b0;

  logic       a_inc_pc, a_load_ir, a_rd, a_wr, a_load_acc, a_load_pc, a_datactl_ena, a_halt;
  logic [3:0] a_phase;
  logic       b_inc_pc, b_load_ir, b_rd, b_wr, b_load_acc, b_load_pc, b_datactl_ena, b_halt;
  logic [3:0] b_phase;

  instr_sequencer #(.SKZ_NEED_VALID(1'b1)) dut (
    .clk1(clk1), .rst(rst), .start(start), .opcode(opcode), .zero(zero),
    .acc_valid(acc_valid), .inc_pc(a_inc_pc), .load_ir(a_load_ir), .rd(a_rd),
    .wr(a_wr), .load_acc(a_load_acc), .load_pc(a_load_pc),
    .datactl_ena(a_datactl_ena), .halt(a_halt), .phase(a_phase)
  );

  instr_sequencer #(.SKZ_NEED_VALID(1'b0)) dut_nv (
    .clk1(clk1), .rst(rst), .start(start), .opcode(opcode), .zero(zero),
    .acc_valid(acc_valid), .inc_pc(b_inc_pc), .load_ir(b_load_ir), .rd(b_rd),
    .wr(b_wr), .load_acc(b_load_acc), .load_pc(b_load_pc),
    .datactl_ena(b_datactl_ena), .halt(b_halt), .phase(b_phase)
  );

  always #5 clk1 = ~clk1;

  // Strobe byte order: {inc_pc, load_ir, rd, wr, load_acc, load_pc, datactl_ena, halt}
  typedef struct {
    logic [11:0] e1;
    logic [11:0] e2;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t push_e;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @%0t: got phase=%0d strobes=%b, expected phase=%0d strobes=%b",
               name, $time, act[11:8], act[7:0], expv[11:8], expv[7:0]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk1);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("dut", {a_phase, a_inc_pc, a_load_ir, a_rd, a_wr, a_load_acc,
                      a_load_pc, a_datactl_ena, a_halt}, mon_e.e1);
        check("dut_nv", {b_phase, b_inc_pc, b_load_ir, b_rd, b_wr, b_load_acc,
                         b_load_pc, b_datactl_ena, b_halt}, mon_e.e2);
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic [2:0] op,
                      input logic z, input logic av,
                      input logic [11:0] e1, input logic [11:0] e2);
    @(negedge clk1);
    rst       = r;
    start     = s;
    opcode    = op;
    zero      = z;
    acc_valid = av;
    push_e.e1 = e1;
    push_e.e2 = e2;
    sb_q.push_back(push_e);
  endtask

  // One full S0..S7 instruction; zero is switched from z5 to z7 after the S5 entry edge.
  task automatic run_instr(input string name, input logic [2:0] op, input logic z5,
                           input logic z7, input logic av,
                           input logic [63:0] v1, input logic [63:0] v2);
    $display("instr %s op=%b zero(S5/S7)=%b/%b acc_valid=%b", name, op, z5, z7, av);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, (i == 0), op, (i >= 6) ? z7 : z5, av,
           {4'(i), v1[63-8*i -: 8]}, {4'(i), v2[63-8*i -: 8]});
    end
  endtask

  localparam logic [63:0] V_ALU   = 64'hE0E0_0080_2028_2000;
  localparam logic [63:0] V_STO   = 64'hE0E0_0080_0212_0200;
  localparam logic [63:0] V_JMP   = 64'hE0E0_0080_0484_0000;
  localparam logic [63:0] V_SKZ_T = 64'hE0E0_0080_0080_0080;
  localparam logic [63:0] V_SKZ_N = 64'hE0E0_0080_0000_0000;
  localparam logic [63:0] V_SKZ_5 = 64'hE0E0_0080_0080_0000;
  localparam logic [11:0] E_IDLE  = 12'h800;
  localparam logic [11:0] E_HALT  = 12'h901;

  initial begin
    $display("reset with start held high");
    step(1'b1, 1'b1, 3'b101, 1'b0, 1'b0, E_IDLE, E_IDLE);
    step(1'b1, 1'b1, 3'b101, 1'b0, 1'b0, E_IDLE, E_IDLE);
    step(1'b0, 1'b0, 3'b101, 1'b0, 1'b0, E_IDLE, E_IDLE);

    run_instr("LDA", 3'b101, 1'b0, 1'b0, 1'b0, V_ALU, V_ALU);
    run_instr("STO", 3'b110, 1'b0, 1'b0, 1'b1, V_STO, V_STO);
    run_instr("SKZ z=1 v=1", 3'b001, 1'b1, 1'b1, 1'b1, V_SKZ_T, V_SKZ_T);
    run_instr("SKZ z=1 v=0", 3'b001, 1'b1, 1'b1, 1'b0, V_SKZ_N, V_SKZ_T);
    run_instr("SKZ z=0 v=1", 3'b001, 1'b0, 1'b0, 1'b1, V_SKZ_N, V_SKZ_N);
    run_instr("SKZ z=1->0", 3'b001, 1'b1, 1'b0, 1'b1, V_SKZ_5, V_SKZ_5);
    run_instr("ADD", 3'b010, 1'b0, 1'b0, 1'b1, V_ALU, V_ALU);
    run_instr("XORR", 3'b100, 1'b1, 1'b1, 1'b1, V_ALU, V_ALU);

    $display("instr HLT op=000 then hold 10 cycles");
    step(1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 12'h0E0, 12'h0E0);
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 12'h1E0, 12'h1E0);
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 12'h200, 12'h200);
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 12'h300, 12'h300);
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, E_HALT, E_HALT);
    end

    run_instr("ANDD after HALT", 3'b011, 1'b0, 1'b0, 1'b1, V_ALU, V_ALU);
    run_instr("JMP", 3'b111, 1'b0, 1'b0, 1'b1, V_JMP, V_JMP);

    $display("instr JMP aborted by rst at S4");
    step(1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 12'h0E0, 12'h0E0);
    step(1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 12'h1E0, 12'h1E0);
    step(1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 12'h200, 12'h200);
    step(1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 12'h380, 12'h380);
    step(1'b1, 1'b1, 3'b111, 1'b0, 1'b1, E_IDLE, E_IDLE);
    step(1'b0, 1'b0, 3'b111, 1'b0, 1'b1, E_IDLE, E_IDLE);
    step(1'b0, 1'b0, 3'b111, 1'b0, 1'b1, E_IDLE, E_IDLE);

    @(negedge clk1);
    @(negedge clk1);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
